// File: rtl/counter_disp_pkg.sv
// Shared types and constants for the BCD display path: FSM states, segment
// patterns and the datapath widths.
package counter_disp_pkg;

  localparam int VALUE_W  = 7;
  localparam int BCD_W    = 8;
  localparam int SHIFT_W  = BCD_W + VALUE_W;
  localparam int MAX_DISP = 99;

  typedef enum logic {
    LOAD  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Active-high segments, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to seven-segment pattern; non-decimal codes
// produce a blank digit.
module seg7_encode
  import counter_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/counter_bcd_display.sv
// Samples the counter value every 8 cycles, converts it to two BCD digits with
// a serial double-dabble shifter and drives a multiplexed 2-digit display.
module counter_bcd_display
  import counter_disp_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_sync,
  input  logic [VALUE_W-1:0] i_value,
  output logic [3:0]         o_tens,
  output logic [3:0]         o_ones,
  output logic               o_valid,
  output logic               o_overflow,
  output logic [1:0]         o_digit_sel,
  output logic [6:0]         o_seg
);

  localparam int         SCAN_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [2:0] LAST_SHIFT = 3'(VALUE_W - 1);

  // Conversion state
  state_e               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [SHIFT_W-1:0]   adjusted, shifted;
  logic [3:0]           tens_d, ones_d;
  logic                 valid_d, overflow_d;

  // Scan / display state
  logic [SCAN_W-1:0]    scan_q, scan_d;
  logic                 scan_wrap;
  logic [1:0]           sel_d;
  logic [3:0]           digit_nib;
  logic [6:0]           digit_seg;
  logic [6:0]           seg_d;

  assign adjusted = {add3(shift_q[SHIFT_W-1 -: 4]), add3(shift_q[SHIFT_W-5 -: 4]),
                     shift_q[VALUE_W-1:0]};
  assign shifted  = {adjusted[SHIFT_W-2:0], 1'b0};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    tens_d     = o_tens;
    ones_d     = o_ones;
    valid_d    = o_valid;
    overflow_d = o_overflow;

    case (state_q)
      LOAD: begin
        shift_d    = {{BCD_W{1'b0}}, i_value};
        cnt_d      = 3'd0;
        ovf_pend_d = (i_value > VALUE_W'(MAX_DISP));
        state_d    = SHIFT;
      end
      SHIFT: begin
        shift_d = shifted;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == LAST_SHIFT) begin
          // No hundreds nibble exists, so an overflowed result is thrown away.
          state_d    = LOAD;
          valid_d    = 1'b1;
          overflow_d = ovf_pend_q;
          tens_d     = ovf_pend_q ? 4'd0 : shifted[SHIFT_W-1 -: 4];
          ones_d     = ovf_pend_q ? 4'd0 : shifted[SHIFT_W-5 -: 4];
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    sel_d     = scan_wrap ? {o_digit_sel[0], o_digit_sel[1]} : o_digit_sel;
    digit_nib = sel_d[1] ? o_tens : o_ones;
  end

  seg7_encode u_seg7_encode (
    .digit (digit_nib),
    .seg   (digit_seg)
  );

  // The pattern follows the digit selected after this edge, but the result
  // registers as they stand before it, so a new result shows one edge later.
  always_comb begin
    seg_d = digit_seg;
    if (!o_valid)
      seg_d = SEG_BLANK;
    else if (o_overflow)
      seg_d = SEG_DASH;
    else if (sel_d[1] && (o_tens == 4'd0))
      seg_d = SEG_BLANK;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset_sync) begin
      state_q     <= LOAD;
      shift_q     <= '0;
      cnt_q       <= 3'd0;
      ovf_pend_q  <= 1'b0;
      o_tens      <= 4'd0;
      o_ones      <= 4'd0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      scan_q      <= '0;
      o_digit_sel <= 2'b01;
      o_seg       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      o_tens      <= tens_d;
      o_ones      <= ones_d;
      o_valid     <= valid_d;
      o_overflow  <= overflow_d;
      scan_q      <= scan_d;
      o_digit_sel <= sel_d;
      o_seg       <= seg_d;
    end
  end

endmodule

// File: tb/tb_counter_bcd_display.sv
// Scoreboard bench: the driver queues the decimal result of every sampled
// value; a monitor checks results, digit select and segments each cycle.
module tb_counter_bcd_display;

  localparam int SCAN_DIV = 4;
  localparam int PERIOD   = 8;

  logic       clk;
  logic       rst;
  logic [6:0] i_value;
  logic [3:0] o_tens, o_ones;
  logic       o_valid, o_overflow;
  logic [1:0] o_digit_sel;
  logic [6:0] o_seg;

  typedef struct {
    int tens;
    int ones;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   edge_idx;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Bench view of what the result registers should hold.
  bit disp_valid;
  bit disp_ovf;
  int disp_tens;
  int disp_ones;

  counter_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clock      (clk),
    .i_reset_sync (rst),
    .i_value      (i_value),
    .o_tens       (o_tens),
    .o_ones       (o_ones),
    .o_valid      (o_valid),
    .o_overflow   (o_overflow),
    .o_digit_sel  (o_digit_sel),
    .o_seg        (o_seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge index since reset release: -1 after a reset edge, k after edge Ek.
  initial edge_idx = -2;
  always @(posedge clk) edge_idx <= rst ? -1 : edge_idx + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_idx, $time);
    end
  endtask

  function automatic exp_t decimal(input int v);
    exp_t e;
    if (v > 99) begin
      e.tens = 0; e.ones = 0; e.ovf = 1'b1;
    end else begin
      e.tens = v / 10; e.ones = v % 10; e.ovf = 1'b0;
    end
    return e;
  endfunction

  // One cycle of stimulus. Only the value present at a LOAD edge is queued;
  // all other cycles carry random values that the block must ignore.
  task automatic step(input logic rst_v, input int load_v);
    @(negedge clk);
    rst = rst_v;
    if (rst_v) begin
      i_value = 7'($urandom_range(0, 127));
      exp_q.delete();
    end else if ((edge_idx + 1) % PERIOD == 0) begin
      i_value = 7'(load_v);
      exp_q.push_back(decimal(load_v));
    end else begin
      i_value = 7'($urandom_range(0, 127));
    end
  endtask

  task automatic run_conv(input int v);
    repeat (PERIOD) step(1'b0, v);
  endtask

  task automatic hold_reset(input int cycles);
    repeat (cycles) step(1'b1, 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (edge_idx == -1) begin
      disp_valid = 1'b0;
      disp_ovf   = 1'b0;
      disp_tens  = 0;
      disp_ones  = 0;
      check("reset_tens",  32'(o_tens),      0);
      check("reset_ones",  32'(o_ones),      0);
      check("reset_valid", 32'(o_valid),     0);
      check("reset_ovf",   32'(o_overflow),  0);
      check("reset_sel",   32'(o_digit_sel), 32'h1);
      check("reset_seg",   32'(o_seg),       0);
    end else if (edge_idx >= 0) begin
      automatic bit         tens_sel = (((edge_idx + 1) / SCAN_DIV) % 2) == 1;
      automatic logic [6:0] exp_seg;
      if (!disp_valid)                    exp_seg = 7'h00;
      else if (disp_ovf)                  exp_seg = 7'h40;
      else if (tens_sel && disp_tens == 0) exp_seg = 7'h00;
      else                                exp_seg = seg_tbl[tens_sel ? disp_tens : disp_ones];
      check("digit_sel", 32'(o_digit_sel), tens_sel ? 32'h2 : 32'h1);
      check("seg",       32'(o_seg),       32'(exp_seg));

      if (edge_idx >= PERIOD - 1 && (edge_idx - (PERIOD - 1)) % PERIOD == 0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL result_queue: got conversion with no queued sample expected one (edge %0d)", edge_idx);
        end else begin
          automatic exp_t e = exp_q.pop_front();
          disp_valid = 1'b1;
          disp_ovf   = e.ovf;
          disp_tens  = e.tens;
          disp_ones  = e.ones;
        end
      end
      check("tens",  32'(o_tens),     32'(disp_tens));
      check("ones",  32'(o_ones),     32'(disp_ones));
      check("valid", 32'(o_valid),    32'(disp_valid));
      check("ovf",   32'(o_overflow), 32'(disp_ovf));
    end
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    i_value = 7'd0;

    hold_reset(3);
    run_conv(0);
    run_conv(42);
    run_conv(42);
    run_conv(7);
    run_conv(7);
    run_conv(99);
    run_conv(100);
    run_conv(13);
    run_conv(127);
    run_conv(10);

    // Abort a conversion of 55 with reset asserted at its E4.
    repeat (4) step(1'b0, 55);
    hold_reset(3);
    run_conv(55);

    repeat (20) run_conv($urandom_range(0, 127));

    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
